// File: rtl/det_event_arb.sv
// rtl/det_event_arb.sv - round-robin arbiter sharing one event-report channel among NCH detectors
//
// Each detector pd output is rising-edge qualified, counted into a per-channel
// saturating pending counter, and drained round-robin through a registered
// valid/ready slot.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   pd_in     detector pd outputs, one bit per channel
//   en        per-channel enable for new events
//   clr       synchronous clear, active-high, highest priority
//   ev_valid  event presented on ev_ch
//   ev_ready  downstream accepts the presented event
//   ev_ch     channel index of the presented event
//   ovf       sticky per-channel pending-counter overflow
//   tot_cnt   total accepted events, wraps
module det_event_arb #(
    parameter int NCH = 4,
    parameter int CW  = 4,
    parameter int TW  = 16,
    localparam int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] pd_in,
    input  logic [NCH-1:0] en,
    input  logic           clr,
    output logic           ev_valid,
    input  logic           ev_ready,
    output logic [CHW-1:0] ev_ch,
    output logic [NCH-1:0] ovf,
    output logic [TW-1:0]  tot_cnt
);

    // PRESENT_RELOAD marks a slot refilled on the same edge as a handshake,
    // i.e. back-to-back delivery; it behaves exactly like PRESENT.
    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_PRESENT_RELOAD
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] pd_q;
    logic [CW-1:0]  pend [NCH];
    logic [CHW-1:0] last;
    logic [CHW-1:0] win;
    logic [CHW-1:0] cand;
    logic           any_pend;
    logic           slot_free;
    logic           load;
    logic           hs;
    logic [NCH-1:0] evt;
    logic [NCH-1:0] ld;

    assign evt       = pd_in & ~pd_q & en;
    assign slot_free = ~ev_valid | ev_ready;
    assign load      = slot_free & any_pend;
    assign hs        = ev_valid & ev_ready;

    // First channel with pending events, searching from last+1 upward.
    always_comb begin
        win      = last;
        cand     = last;
        any_pend = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CHW'((int'(last) + k) % NCH);
            if (!any_pend && pend[cand] != '0) begin
                any_pend = 1'b1;
                win      = cand;
            end
        end
    end

    always_comb begin
        ld = '0;
        for (int i = 0; i < NCH; i++) begin
            ld[i] = load && (win == CHW'(i));
        end
    end

    // Slot FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot FSM: next state
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else if (slot_free) begin
            if (load) begin
                state_d = (state_q == S_IDLE) ? S_PRESENT : S_PRESENT_RELOAD;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Slot FSM: outputs
    always_comb begin
        ev_valid = (state_q != S_IDLE);
    end

    // Datapath: edge history, pending counters, slot channel, totals
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pd_q    <= '0;
            ovf     <= '0;
            tot_cnt <= '0;
            ev_ch   <= '0;
            last    <= CHW'(NCH - 1);
            for (int i = 0; i < NCH; i++) pend[i] <= '0;
        end else if (clr) begin
            pd_q    <= '0;
            ovf     <= '0;
            tot_cnt <= '0;
            ev_ch   <= '0;
            last    <= CHW'(NCH - 1);
            for (int i = 0; i < NCH; i++) pend[i] <= '0;
        end else begin
            pd_q    <= pd_in;
            tot_cnt <= tot_cnt + TW'(hs);
            if (load) begin
                ev_ch <= win;
                last  <= win;
            end
            for (int i = 0; i < NCH; i++) begin
                // A same-cycle event and load cancel, even when saturated.
                if (evt[i] && !ld[i]) begin
                    if (pend[i] == '1) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        pend[i] <= pend[i] + 1'b1;
                    end
                end else if (!evt[i] && ld[i]) begin
                    pend[i] <= pend[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_det_event_arb.sv
// tb/tb_det_event_arb.sv - directed table-driven bench for det_event_arb
module tb_det_event_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  pd_in;
    logic [3:0]  en;
    logic        clr;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_ch;
    logic [3:0]  ovf;
    logic [15:0] tot_cnt;

    int n_vec;
    int n_bad;

    det_event_arb #(.NCH(4), .CW(4), .TW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .pd_in    (pd_in),
        .en       (en),
        .clr      (clr),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ch    (ev_ch),
        .ovf      (ovf),
        .tot_cnt  (tot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pd;
        logic [3:0]  en;
        logic        clr;
        logic        rdy;
        logic        valid;
        logic [1:0]  ch;
        logic [15:0] tot;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] p, logic [3:0] e, logic c, logic r,
                                logic v, logic [1:0] ch, logic [15:0] t);
        vec_t x;
        x.pd = p; x.en = e; x.clr = c; x.rdy = r;
        x.valid = v; x.ch = ch; x.tot = t;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves one event in the slot (ch2, not accepted) and one pending on ch2.
    task automatic build_busy();
        ev_ready = 1'b0;
        pd_in = 4'b0100; tick();
        pd_in = 4'b0000; tick();
        pd_in = 4'b0100; tick();
        pd_in = 4'b0000;
        chk("busy_valid", 32'(ev_valid), 32'd1);
        chk("busy_ch", 32'(ev_ch), 32'd2);
    endtask

    task automatic expect_silence(string name);
        int seen;
        seen = 0;
        ev_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ev_valid) seen++;
            tick();
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    int exp4[8];
    int got;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        pd_in = '0;
        en = 4'b1111;
        clr = 1'b0;
        ev_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_ch", 32'(ev_ch), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_tot", 32'(tot_cnt), 32'd0);
        rst = 1'b1;
        tick();

        // single pulse on ch2
        tbl.push_back(mk(4'b0100, 4'hf, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 1, 2, 0));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 0, 0, 1));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 0, 0, 1));
        // clear, then all four channels at once
        tbl.push_back(mk(4'b0000, 4'hf, 1, 1, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 4'hf, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 1, 1, 1));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 1, 2, 2));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 1, 3, 3));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 0, 0, 4));
        // ch0 held high 10 cycles is one event
        tbl.push_back(mk(4'b0001, 4'hf, 0, 1, 0, 0, 4));
        tbl.push_back(mk(4'b0001, 4'hf, 0, 1, 1, 0, 4));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(4'b0001, 4'hf, 0, 1, 0, 0, 5));
        // fall then rise gives a second event
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 0, 0, 5));
        tbl.push_back(mk(4'b0001, 4'hf, 0, 1, 0, 0, 5));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 1, 0, 5));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 0, 0, 6));
        // disabled ch3 ignores its rising edge
        tbl.push_back(mk(4'b1000, 4'b0111, 0, 1, 0, 0, 6));
        tbl.push_back(mk(4'b0000, 4'b0111, 0, 1, 0, 0, 6));
        tbl.push_back(mk(4'b0000, 4'hf, 0, 1, 0, 0, 6));

        foreach (tbl[k]) begin
            pd_in = tbl[k].pd;
            en = tbl[k].en;
            clr = tbl[k].clr;
            ev_ready = tbl[k].rdy;
            tick();
            chk($sformatf("v%0d_valid", k), 32'(ev_valid), 32'(tbl[k].valid));
            chk($sformatf("v%0d_tot", k), 32'(tot_cnt), 32'(tbl[k].tot));
            chk($sformatf("v%0d_ovf", k), 32'(ovf), 32'd0);
            if (tbl[k].valid) chk($sformatf("v%0d_ch", k), 32'(ev_ch), 32'(tbl[k].ch));
        end
        pd_in = '0; en = 4'hf; clr = 1'b0;

        // 17 pulses on ch1 with the port stalled: 16 stored, 17th overflows
        clr = 1'b1; tick(); clr = 1'b0;
        ev_ready = 1'b0;
        for (int p = 1; p <= 17; p++) begin
            if (p == 17) chk("ovf_before_17", 32'(ovf), 32'd0);
            pd_in = 4'b0010; tick();
            pd_in = 4'b0000; tick();
        end
        chk("ovf_after_17", 32'(ovf), 32'b0010);
        ev_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (ev_valid) begin
                chk("drain_ch", 32'(ev_ch), 32'd1);
                got++;
            end
            tick();
        end
        chk("drain_count", 32'(got), 32'd16);
        chk("drain_tot", 32'(tot_cnt), 32'd16);
        chk("drain_ovf_sticky", 32'(ovf), 32'b0010);

        // ch0 and ch3 backlog alternates grants
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        ev_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            pd_in = 4'b1001; tick();
            pd_in = 4'b0000; tick();
        end
        exp4 = '{0, 3, 0, 3, 0, 3, 0, 3};
        ev_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr%0d_valid", k), 32'(ev_valid), 32'd1);
            chk($sformatf("rr%0d_ch", k), 32'(ev_ch), 32'(exp4[k]));
            tick();
        end
        chk("rr_done_valid", 32'(ev_valid), 32'd0);
        chk("rr_tot", 32'(tot_cnt), 32'd8);

        // async reset mid-handshake
        build_busy();
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(ev_valid), 32'd0);
        chk("arst_ch", 32'(ev_ch), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_tot", 32'(tot_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_silence("arst_no_event");
        chk("arst_tot_after", 32'(tot_cnt), 32'd0);

        // same with synchronous clear
        pd_in = 4'b0010; tick();
        pd_in = 4'b0000; tick(); tick();
        chk("pre_clr_tot", 32'(tot_cnt), 32'd1);
        build_busy();
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_valid", 32'(ev_valid), 32'd0);
        chk("clr_ch", 32'(ev_ch), 32'd0);
        chk("clr_tot", 32'(tot_cnt), 32'd0);
        expect_silence("clr_no_event");
        chk("clr_tot_after", 32'(tot_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
